// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scan controller.
//   SEG7_BLANK - active-low segment pattern with every segment dark
//   NIB_BLANK  - nibble code the decoder renders as a blank digit
//   NIB_DASH   - nibble code the decoder renders as a centre dash (sign)
//   scanState_e - per-slot phase: StGuard (anti-ghost blank) or StShow (lit)
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;
  localparam logic [3:0] NIB_BLANK  = 4'hF;
  localparam logic [3:0] NIB_DASH   = 4'hE;

  typedef enum logic {StGuard, StShow} scanState_e;

endpackage

// File: rtl/seven_seg.sv
// seven_seg: combinational hex to seven-segment decoder, active-low outputs.
// Ports:
//   iNIB  [3:0] - nibble to display; NIB_DASH shows a dash, NIB_BLANK shows nothing
//   oSEG7 [6:0] - active-low segments {g,f,e,d,c,b,a}
module seven_seg
  import seg7_pkg::*;
(
  input  logic [3:0] iNIB,
  output logic [6:0] oSEG7
);

  always_comb begin
    oSEG7 = SEG7_BLANK;
    case (iNIB)
      4'h0:      oSEG7 = 7'b1000000;
      4'h1:      oSEG7 = 7'b1111001;
      4'h2:      oSEG7 = 7'b0100100;
      4'h3:      oSEG7 = 7'b0110000;
      4'h4:      oSEG7 = 7'b0011001;
      4'h5:      oSEG7 = 7'b0010010;
      4'h6:      oSEG7 = 7'b0000010;
      4'h7:      oSEG7 = 7'b1111000;
      4'h8:      oSEG7 = 7'b0000000;
      4'h9:      oSEG7 = 7'b0010000;
      4'hA:      oSEG7 = 7'b0001000;
      4'hB:      oSEG7 = 7'b0000011;
      4'hC:      oSEG7 = 7'b1000110;
      4'hD:      oSEG7 = 7'b0100001;
      NIB_DASH:  oSEG7 = 7'b0111111;
      NIB_BLANK: oSEG7 = SEG7_BLANK;
      default:   oSEG7 = SEG7_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan of NDIG common-anode digits through one
// shared seven_seg decoder, with a blank guard at each slot start and a
// double-buffered display value that only changes on frame boundaries.
// Optional feature: define SEG7_LZB_EN for leading-zero blanking (digit 0 never blanked).
// Parameters: NDIG (1..8), PRESCALE (cycles per slot, >= GUARD+2), GUARD (>= 1).
// Ports:
//   iCLK, iRST_N      - clock, asynchronous active-low reset
//   iDATA [4*NDIG-1:0] - packed nibbles, digit 0 rightmost
//   iDIG_EN [NDIG-1:0] - live per-digit enable
//   iLOAD             - capture iDATA into the shadow register
//   oSEG7 [6:0]       - active-low segments {g,f,e,d,c,b,a}, registered
//   oAN [NDIG-1:0]    - active-low digit select, registered
//   oFRAME            - one-cycle pulse on the first cycle of each frame
//   oPEND             - shadow holds data not yet promoted to the active value
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned GUARD    = 8
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [4*NDIG-1:0] iDATA,
  input  logic [NDIG-1:0]   iDIG_EN,
  input  logic              iLOAD,
  output logic [6:0]        oSEG7,
  output logic [NDIG-1:0]   oAN,
  output logic              oFRAME,
  output logic              oPEND
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CntW-1:0]   cntQ, cntD;
  logic [IdxW-1:0]   idxQ, idxD;
  scanState_e        stateQ, stateD;
  logic [4*NDIG-1:0] shadowQ, shadowD;
  logic [4*NDIG-1:0] activeQ, activeD;
  logic              pendQ, pendD;
  logic [6:0]        segQ, segD;
  logic [NDIG-1:0]   anQ, anD;
  logic              frameQ, frameD;

  logic              slotEnd, frameWrap;
  logic [4*NDIG-1:0] dispData;
  logic [3:0]        nib;
  logic [6:0]        decSeg;

  assign slotEnd   = (cntQ == CntW'(PRESCALE - 1));
  assign frameWrap = slotEnd && (idxQ == IdxW'(NDIG - 1));

  // Counter, slot index and double buffer
  always_comb begin
    cntD    = slotEnd ? '0 : cntQ + CntW'(1);
    idxD    = idxQ;
    if (slotEnd) idxD = frameWrap ? '0 : idxQ + IdxW'(1);
    stateD  = (cntD < CntW'(GUARD)) ? StGuard : StShow;
    shadowD = shadowQ;
    activeD = activeQ;
    pendD   = pendQ;
    frameD  = frameWrap;
    if (frameWrap && pendQ) begin
      activeD = shadowQ;
      pendD   = 1'b0;
    end
    if (iLOAD) begin
      shadowD = iDATA;
      // A load landing on the wrap edge goes straight to the new frame.
      if (frameWrap) activeD = iDATA;
      else           pendD   = 1'b1;
    end
  end

`ifdef SEG7_LZB_EN
  // Blank zeros from the top digit down until the first nonzero nibble.
  always_comb begin
    logic leading;
    dispData = activeQ;
    leading  = 1'b1;
    for (int i = int'(NDIG) - 1; i >= 1; i--) begin
      if (leading && (activeQ[4*i +: 4] == 4'h0)) dispData[4*i +: 4] = NIB_BLANK;
      else                                       leading = 1'b0;
    end
  end
`else
  assign dispData = activeQ;
`endif

  // Slot mux written as a compare loop so non-power-of-two NDIG stays in range
  always_comb begin
    nib = NIB_BLANK;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (idxQ == IdxW'(i)) nib = dispData[4*i +: 4];
    end
  end

  seven_seg uDec (
    .iNIB  (nib),
    .oSEG7 (decSeg)
  );

  always_comb begin
    segD = (stateQ == StShow) ? decSeg : SEG7_BLANK;
    anD  = '1;
    for (int i = 0; i < int'(NDIG); i++) begin
      anD[i] = !((stateQ == StShow) && (idxQ == IdxW'(i)) && iDIG_EN[i]);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cntQ    <= '0;
      idxQ    <= '0;
      stateQ  <= StGuard;
      shadowQ <= {NDIG{NIB_BLANK}};
      activeQ <= {NDIG{NIB_BLANK}};
      pendQ   <= 1'b0;
      segQ    <= SEG7_BLANK;
      anQ     <= '1;
      frameQ  <= 1'b0;
    end else begin
      cntQ    <= cntD;
      idxQ    <= idxD;
      stateQ  <= stateD;
      shadowQ <= shadowD;
      activeQ <= activeD;
      pendQ   <= pendD;
      segQ    <= segD;
      anQ     <= anD;
      frameQ  <= frameD;
    end
  end

  assign oSEG7  = segQ;
  assign oAN    = anQ;
  assign oFRAME = frameQ;
  assign oPEND  = pendQ;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIG=4, PRESCALE=16, GUARD=2.
// Outputs are sampled on the falling edge; frame position j counts falling
// edges from the one where oFRAME is seen high (j=0). Output at j reflects
// the slot position j-1, so slot s guard is j=16s+1..16s+2, lit 16s+3..16s+16.
module tb_seg7_scan_ctrl;

  localparam int unsigned NDIG = 4;
  localparam int unsigned PRE  = 16;
  localparam int unsigned GRD  = 2;
  localparam int unsigned FLEN = NDIG * PRE;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000, S8 = 7'b0000000, SB = 7'h7F;

  logic              iCLK = 1'b0;
  logic              iRST_N;
  logic [4*NDIG-1:0] iDATA;
  logic [NDIG-1:0]   iDIG_EN;
  logic              iLOAD;
  logic [6:0]        oSEG7;
  logic [NDIG-1:0]   oAN;
  logic              oFRAME;
  logic              oPEND;

  int checks = 0;
  int errors = 0;

  logic [3:0] anArr   [FLEN];
  logic [6:0] segArr  [FLEN];
  logic       frArr   [FLEN];
  logic       pendArr [FLEN];

  seg7_scan_ctrl #(.NDIG(NDIG), .PRESCALE(PRE), .GUARD(GRD)) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iDATA   (iDATA),
    .iDIG_EN (iDIG_EN),
    .iLOAD   (iLOAD),
    .oSEG7   (oSEG7),
    .oAN     (oAN),
    .oFRAME  (oFRAME),
    .oPEND   (oPEND)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    checks++;
    if (obs !== expVal) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expVal);
    end
  endtask

  task automatic stepN(input int n);
    for (int k = 0; k < n; k++) @(negedge iCLK);
  endtask

  // Advance to the next falling edge where oFRAME is high.
  task automatic waitFrame();
    int n;
    n = 0;
    @(negedge iCLK);
    while (oFRAME !== 1'b1 && n < 300) begin
      @(negedge iCLK);
      n++;
    end
    if (oFRAME !== 1'b1) check("frameTimeout", 32'd0, 32'd1);
  endtask

  // Record one frame starting at j=0, then confirm the next frame pulse lands at j=FLEN.
  task automatic captureFrame();
    int extra;
    extra = 0;
    for (int j = 0; j < int'(FLEN); j++) begin
      anArr[j]   = oAN;
      segArr[j]  = oSEG7;
      frArr[j]   = oFRAME;
      pendArr[j] = oPEND;
      if (j > 0 && oFRAME) extra++;
      @(negedge iCLK);
    end
    check("framePeriod", {31'd0, oFRAME}, 32'd1);
    check("noExtraFrame", extra, 0);
  endtask

  task automatic loadPulse(input logic [15:0] d);
    iLOAD = 1'b1;
    iDATA = d;
    @(negedge iCLK);
    iLOAD = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    iRST_N  = 1'b0;
    iDATA   = '0;
    iDIG_EN = 4'hF;
    iLOAD   = 1'b0;

    // Reset state
    stepN(3);
    check("rstAn", oAN, 4'hF);
    check("rstSeg", oSEG7, SB);
    check("rstFrame", oFRAME, 1'b0);
    check("rstPend", oPEND, 1'b0);
    iRST_N = 1'b1;

    // Normal display of 1234
    stepN(2);
    loadPulse(16'h1234);
    check("pendAfterLoad", oPEND, 1'b1);
    waitFrame();
    check("pendClearedAtFrame", oPEND, 1'b0);
    captureFrame();
    check("s0Guard1An", anArr[1], 4'hF);
    check("s0Guard2Seg", segArr[2], SB);
    check("s0LitAn", anArr[3], 4'b1110);
    check("s0LitSeg", segArr[3], S4);
    check("s0LastSeg", segArr[16], S4);
    cnt = 0;
    for (int j = 0; j < int'(FLEN); j++) if (anArr[j] == 4'b1110) cnt++;
    check("s0LitCount", cnt, 14);
    check("s1Seg", segArr[20], S3);
    check("s2Seg", segArr[36], S2);
    check("s3An", anArr[51], 4'b0111);
    check("s3Seg", segArr[51], S1);

    // Digit 2 disabled: slot stays dark but still consumes its time
    iDIG_EN = 4'b1011;
    captureFrame();
    cnt = 0;
    for (int j = 33; j <= 48; j++) if (anArr[j] != 4'hF) cnt++;
    check("s2DisabledLit", cnt, 0);
    check("s1StillOn", anArr[20], 4'b1101);
    check("s3StillOn", anArr[51], 4'b0111);
    iDIG_EN = 4'hF;

    // Two mid-frame loads: last wins, shown only after the wrap
    stepN(20);
    loadPulse(16'h1111);
    check("pendMidLoad", oPEND, 1'b1);
    stepN(9);
    loadPulse(16'h2222);
    check("oldValueHeld", segArr[0] === SB ? oSEG7 : oSEG7, S3);
    stepN(32);
    check("pendBeforeWrap", oPEND, 1'b1);
    @(negedge iCLK);
    check("frameAfterLoads", oFRAME, 1'b1);
    check("pendFallsWithFrame", oPEND, 1'b0);
    captureFrame();
    check("newS0Seg", segArr[3], S2);
    check("newS3Seg", segArr[51], S2);

    // Load exactly on the wrap edge
    stepN(63);
    loadPulse(16'h5678);
    check("wrapLoadFrame", oFRAME, 1'b1);
    check("wrapLoadPend", oPEND, 1'b0);
    captureFrame();
    cnt = 0;
    for (int j = 0; j < int'(FLEN); j++) if (pendArr[j]) cnt++;
    check("wrapLoadPendNever", cnt, 0);
    check("wrapS0Seg", segArr[3], S8);
    check("wrapS3Seg", segArr[51], S5);

    // Leading zeros
    stepN(5);
    loadPulse(16'h0070);
    waitFrame();
    captureFrame();
    check("lz70S0", segArr[3], S0);
    check("lz70S1", segArr[19], S7);
    check("lz70S3An", anArr[51], 4'b0111);
`ifdef SEG7_LZB_EN
    check("lz70S2", segArr[35], SB);
    check("lz70S3", segArr[51], SB);
`else
    check("lz70S2", segArr[35], S0);
    check("lz70S3", segArr[51], S0);
`endif
    stepN(5);
    loadPulse(16'h0000);
    waitFrame();
    captureFrame();
    check("lz00S0", segArr[3], S0);
`ifdef SEG7_LZB_EN
    check("lz00S1", segArr[19], SB);
`else
    check("lz00S1", segArr[19], S0);
`endif

    // Reset asserted while a digit is lit
    loadPulse(16'h1234);
    stepN(4);
    check("preResetLit", oAN, 4'b1110);
    check("preResetPend", oPEND, 1'b1);
    iRST_N = 1'b0;
    #1;
    check("midRstAn", oAN, 4'hF);
    check("midRstSeg", oSEG7, SB);
    check("midRstFrame", oFRAME, 1'b0);
    check("midRstPend", oPEND, 1'b0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    cnt = 0;
    do begin
      @(negedge iCLK);
      cnt++;
    end while (oFRAME !== 1'b1 && cnt < 200);
    check("firstFrameAfterRst", cnt, FLEN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller that shares one `seven_seg` hex decoder across `NDIG` common-anode digits of the board display. It sequences digit slots from a prescaler, inserts an anti-ghosting guard at each slot start, and double-buffers the displayed value so a frame never tears. It sits between counter/status logic that produces packed BCD/hex nibbles and the board's shared segment/anode pins.

## Interface
- `NDIG`, 4: number of digits, 1..8
- `PRESCALE`, 50000: clock cycles per digit slot, must be ≥ `GUARD`+2
- `GUARD`, 8: blank cycles at the start of each slot, ≥1
- `iCLK` input 1: single clock for all state
- `iRST_N` input 1: reset, asynchronous and active-low
- `iDATA` input 4*NDIG: packed nibbles; digit i = `iDATA[4i+3:4i]`; digit 0 is rightmost
- `iDIG_EN` input NDIG: per-digit enable, sampled live every cycle
- `iLOAD` input 1: capture `iDATA` into the shadow register on this edge
- `oSEG7` output 7: active-low segments {g,f,e,d,c,b,a}, registered
- `oAN` output NDIG: active-low digit select, registered, at most one bit low
- `oFRAME` output 1: one-cycle pulse on the first cycle of each frame
- `oPEND` output 1: shadow holds data not yet promoted to the active register

## Operation
- Registers: `cnt` (0..PRESCALE-1), `idx` (0..NDIG-1), `shadow` and `active` (4*NDIG each), `pend`, `state` ∈ {GUARD, SHOW}.
- `cnt` increments every cycle. At `PRESCALE`-1 it wraps to 0, `idx` advances, and state returns to GUARD.
- GUARD: applies while `cnt` < `GUARD`. Drives all `oAN` high and `oSEG7` = 7'h7F.
- SHOW: applies while `cnt` ≥ `GUARD`. Drives `oAN[idx]` low only if `iDIG_EN[idx]`, otherwise all high. Drives `oSEG7` from `seven_seg` of `active` nibble `idx`.
- Disabled digits still consume their full slot, so frame period and brightness stay constant.
- Frame wrap occurs when `idx`=NDIG-1 and `cnt`=PRESCALE-1:
  - `idx`→0.
  - If `pend`, `active`←`shadow` and `pend`←0.
  - `oFRAME` pulses in the next cycle.
- `iLOAD`: `shadow`←`iDATA` and `pend`←1. Multiple loads in one frame: the last one wins.
- `iLOAD` on the frame-wrap edge: `iDATA` is written to both `shadow` and `active`, and `pend` stays 0. The new value is shown in the starting frame.
- Codes 4'hE (dash) and 4'hF (blank) pass through the decoder unchanged. Applications use them for sign and blanking.
- Reset values: `cnt`=0, `idx`=0, state GUARD, `shadow`=`active`={NDIG{4'hF}}, `pend`=0, `oAN`=all 1, `oSEG7`=7'h7F, `oFRAME`=0, `oPEND`=0.
- Reset mid-frame aborts immediately to the reset values. After release, the first frame starts at slot 0 in GUARD.

## Timing
- All outputs are registered. Output values in cycle k reflect `cnt`/`idx`/`state` of cycle k-1.
- Slot period is `PRESCALE` cycles: `GUARD` cycles blank, then `PRESCALE`-`GUARD` cycles lit.
- Frame period is `NDIG`·`PRESCALE` cycles. `oFRAME` period is identical.
- `iLOAD` to `oPEND` high: 1 cycle, except on a wrap-coincident load, where `oPEND` stays 0.
- `oPEND` falls in the cycle `oFRAME` rises.
- No backpressure. `iLOAD` is accepted every cycle.

## Configuration
- Macro: `SEG7_LZB_EN`.
- Defined: leading-zero blanking.
  - Scanning from digit NDIG-1 downward, each `active` nibble equal to 0 is replaced by 4'hF until the first nonzero nibble.
  - Digit 0 is never blanked.
  - Applied combinationally on the `active` path. `shadow` and `active` contents are unmodified.
- Undefined: all nibbles are decoded as stored.

## Structure
- Shared package `seg7_pkg` holds:
  - `SEG7_BLANK`=7'h7F
  - `NIB_BLANK`=4'hF
  - `NIB_DASH`=4'hE
  - state enum {GUARD, SHOW}
- One sub-module: the existing `seven_seg` decoder, instantiated once on the muxed nibble.
- Counter, mux, buffering and blanking logic stay in this module.

## Test plan
- Reset behaviour: with `NDIG`=4, `PRESCALE`=16, `GUARD`=2, hold `iRST_N` low → `oAN`=4'hF, `oSEG7`=7'h7F, `oFRAME`=0, `oPEND`=0. Reassert reset mid-SHOW → same values within the same cycle.
- Normal display: load 16'h1234 and wait for `oFRAME` → slot 0: `oAN`=4'b1110, `oSEG7`=7'b0011001 (4) for 14 cycles after 2 blank cycles; slot 3: `oAN`=4'b0111, `oSEG7`=7'b1111001 (1); `oFRAME` period 64 cycles.
- Digit disable: `iDIG_EN`=4'b1011 → slot 2 holds `oAN`=4'hF for all 16 cycles; frame period stays 64.
- Mid-frame loads: `iLOAD` with 16'h1111 then 16'h2222 mid-frame → `oPEND`=1; displayed value unchanged until wrap; next frame shows 2222; `oPEND` falls with `oFRAME`.
- Load on wrap: `iLOAD` exactly on the wrap edge → new value shown in the starting frame; `oPEND` never rises.
- Leading-zero blanking: with `SEG7_LZB_EN`, load 16'h0070 → digits 3 and 2 blank (7'h7F), digit 1 shows 7'b1111000, digit 0 shows 7'b1000000. Load 16'h0000 → only digit 0 lit. Without the macro, 16'h0070 shows all four digits.
